// File: rtl/apb_uart_arbiter.sv
// -----------------------------------------------------------------------------
// apb_uart_arbiter
//
// Two-requester APB master. Two on-chip clients (for example a boot/config
// sequencer and a data mover) share the single APB slave port of the UART.
// Each client issues one read or write at a time over a valid/done handshake.
// The block picks a winner round-robin, runs one full APB SETUP/ACCESS
// transfer for it, and returns PRDATA/PSLVERR as a one-cycle done pulse.
// A transfer whose slave never raises PREADY is abandoned after
// TIMEOUT_CYCLES wait cycles and reported to the requester as an error.
//
// Ports
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   reqN_valid               request pending, held until reqN_done (N = 0,1)
//   reqN_write               1 = write, 0 = read
//   reqN_addr, reqN_wdata    address / write data, captured at grant
//   reqN_done                one-cycle completion pulse
//   reqN_rdata               read data while reqN_done, 0 otherwise
//   reqN_err                 slave error or timeout while reqN_done
//   PSELx, PENABLE, PWRITE   APB master controls
//   PADDR, PWDATA            APB address / write data
//   PRDATA, PREADY, PSLVERR  APB slave response
//   busy                     high whenever the FSM is not in IDLE
//
// Every output is a flop. The combinational process computes the value each
// output must have in the next state, so outputs line up with the state
// register without an extra cycle of latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module apb_uart_arbiter #(
    parameter int          DATA_WIDTH     = `DATA_WIDTH,
    parameter int          ADDR_WIDTH     = `ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,

    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,

    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,

    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,

    output logic                  busy
);

    // Counter only needs to reach TIMEOUT_CYCLES; keep at least one bit so a
    // disabled timeout (0) still elaborates cleanly.
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_next;

    // Which requester owns the transfer in flight, and which one won the
    // previous grant (drives the round-robin tie break).
    logic grant_id,   grant_id_next;
    logic last_grant, last_grant_next;

    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;

    logic                  psel_next;
    logic                  penable_next;
    logic                  pwrite_next;
    logic [ADDR_WIDTH-1:0] paddr_next;
    logic [DATA_WIDTH-1:0] pwdata_next;
    logic                  busy_next;
    logic                  done0_next, done1_next;
    logic [DATA_WIDTH-1:0] rdata0_next, rdata1_next;
    logic                  err0_next, err1_next;

    // Response being handed back this cycle (valid only with resp_fire).
    logic                  resp_fire;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;
    logic                  winner;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        grant_id_next   = grant_id;
        last_grant_next = last_grant;
        wait_cnt_next   = wait_cnt;

        // The APB payload registers double as the captured request, so they
        // hold their value unless a new grant is issued.
        pwrite_next     = PWRITE;
        paddr_next      = PADDR;
        pwdata_next     = PWDATA;

        psel_next       = 1'b0;
        penable_next    = 1'b0;

        resp_fire       = 1'b0;
        resp_data       = '0;
        resp_err        = 1'b0;
        winner          = 1'b0;

        unique case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the requester that did not win last time goes
                    // first; otherwise the lone valid requester wins.
                    if (req0_valid && req1_valid) begin
                        winner = ~last_grant;
                    end else begin
                        winner = req1_valid;
                    end

                    grant_id_next   = winner;
                    last_grant_next = winner;
                    if (winner) begin
                        pwrite_next = req1_write;
                        paddr_next  = req1_addr;
                        pwdata_next = req1_wdata;
                    end else begin
                        pwrite_next = req0_write;
                        paddr_next  = req0_addr;
                        pwdata_next = req0_wdata;
                    end
                    psel_next  = 1'b1;
                    state_next = SETUP;
                end
            end

            SETUP: begin
                psel_next     = 1'b1;
                penable_next  = 1'b1;
                wait_cnt_next = '0;
                state_next    = ACCESS;
            end

            ACCESS: begin
                if (PREADY) begin
                    // PSLVERR is only meaningful in the PREADY cycle; a write
                    // returns zero data regardless of what the slave drives.
                    resp_fire  = 1'b1;
                    resp_err   = PSLVERR;
                    resp_data  = PWRITE ? '0 : PRDATA;
                    state_next = RESP;
                end else if (TIMEOUT_EN && (wait_cnt == TIMEOUT_VAL)) begin
                    // Abandon the transfer: select/enable drop as RESP begins.
                    resp_fire  = 1'b1;
                    resp_err   = 1'b1;
                    resp_data  = '0;
                    state_next = RESP;
                end else begin
                    psel_next    = 1'b1;
                    penable_next = 1'b1;
                    if (TIMEOUT_EN) begin
                        wait_cnt_next = wait_cnt + 1'b1;
                    end
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        done0_next  = resp_fire && !grant_id;
        done1_next  = resp_fire &&  grant_id;
        rdata0_next = done0_next ? resp_data : '0;
        rdata1_next = done1_next ? resp_data : '0;
        err0_next   = done0_next && resp_err;
        err1_next   = done1_next && resp_err;

        busy_next   = (state_next != IDLE);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            PSELx      <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            busy       <= 1'b0;
            req0_done  <= 1'b0;
            req0_rdata <= '0;
            req0_err   <= 1'b0;
            req1_done  <= 1'b0;
            req1_rdata <= '0;
            req1_err   <= 1'b0;
        end else begin
            state      <= state_next;
            grant_id   <= grant_id_next;
            last_grant <= last_grant_next;
            wait_cnt   <= wait_cnt_next;
            PSELx      <= psel_next;
            PENABLE    <= penable_next;
            PWRITE     <= pwrite_next;
            PADDR      <= paddr_next;
            PWDATA     <= pwdata_next;
            busy       <= busy_next;
            req0_done  <= done0_next;
            req0_rdata <= rdata0_next;
            req0_err   <= err0_next;
            req1_done  <= done1_next;
            req1_rdata <= rdata1_next;
            req1_err   <= err1_next;
        end
    end

endmodule

// File: tb/tb_apb_uart_arbiter.sv
`timescale 1ns/1ps

module tb_apb_uart_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          req0_valid, req0_write, req0_done, req0_err;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic          req1_valid, req1_write, req1_done, req1_err;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic          PSELx, PENABLE, PWRITE, PREADY, PSLVERR, busy;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;

    int checks = 0;
    int errors = 0;

    // Slave behaviour knobs
    int            cfg_waits;
    logic [DW-1:0] cfg_rdata;
    logic          cfg_err;

    typedef struct {
        int            id;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    apb_uart_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req0_valid(req0_valid),
        .req0_write(req0_write),
        .req0_addr (req0_addr),
        .req0_wdata(req0_wdata),
        .req0_done (req0_done),
        .req0_rdata(req0_rdata),
        .req0_err  (req0_err),
        .req1_valid(req1_valid),
        .req1_write(req1_write),
        .req1_addr (req1_addr),
        .req1_wdata(req1_wdata),
        .req1_done (req1_done),
        .req1_rdata(req1_rdata),
        .req1_err  (req1_err),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .busy      (busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int id, input logic wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [DW-1:0] rd, input logic er);
        exp_t e;
        e.id = id; e.wr = wr; e.addr = a; e.wdata = d; e.rdata = rd; e.err = er;
        return e;
    endfunction

    task automatic drive_req(input int id, input logic v, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id == 0) begin
            req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic set_valid(input int id, input logic v);
        if (id == 0) req0_valid = v;
        else         req1_valid = v;
    endtask

    // Simple APB slave: PREADY rises after cfg_waits ACCESS cycles. While not
    // ready it drives junk PRDATA and PSLVERR=1, which must be ignored.
    initial begin : slave
        int acc;
        acc = 0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (PSELx && PENABLE) begin
                PREADY  = (acc == cfg_waits);
                PRDATA  = PREADY ? cfg_rdata : 32'hDEAD_BEEF;
                PSLVERR = PREADY ? cfg_err : 1'b1;
                acc++;
            end else begin
                acc = 0;
                PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
            end
        end
    end

    // Scoreboard monitor: SETUP payload and done responses against the queue.
    always @(negedge PCLK) begin
        if (PRESETn === 1'b1) begin
            if (PSELx && !PENABLE) begin
                if (q.size() == 0) begin
                    chk("setup_unexpected", PSELx, 0);
                end else begin
                    chk("setup_paddr",  PADDR,  q[0].addr);
                    chk("setup_pwrite", PWRITE, q[0].wr);
                    chk("setup_pwdata", PWDATA, q[0].wdata);
                end
            end
            if (req0_done || req1_done) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", req0_done | req1_done, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("done_port0", req0_done, mon_e.id == 0);
                    chk("done_port1", req1_done, mon_e.id == 1);
                    chk("done_rdata", (mon_e.id == 0) ? req0_rdata : req1_rdata, mon_e.rdata);
                    chk("done_err",   (mon_e.id == 0) ? req0_err   : req1_err,   mon_e.err);
                end
            end
            if (!req0_done) chk("rdata0_idle", req0_rdata, 0);
            if (!req1_done) chk("rdata1_idle", req1_rdata, 0);
        end
    end

    // One complete transaction for a single requester, with cycle checks.
    task automatic do_txn(input int id, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int waits,
                          input logic [DW-1:0] srd, input logic serr);
        bit timed_out;
        int cyc;
        int exp_lat;
        timed_out = (waits > TO);
        exp_lat   = timed_out ? TO + 3 : 3 + waits;
        q.push_back(mk(id, wr, a, d, (wr || timed_out) ? 32'h0 : srd, timed_out ? 1'b1 : serr));
        cfg_waits = waits; cfg_rdata = srd; cfg_err = serr;
        drive_req(id, 1'b1, wr, a, d);
        cyc = 0;
        do begin
            @(posedge PCLK); #1;
            cyc++;
            if (cyc == 1) begin
                chk("setup_psel", PSELx, 1);
                chk("setup_penable", PENABLE, 0);
                // Payload changes after the grant must not reach the bus.
                drive_req(id, 1'b1, wr, ~a, ~d);
            end
            if (cyc == 2) begin
                chk("access_psel", PSELx, 1);
                chk("access_penable", PENABLE, 1);
            end
        end while (!((id == 0) ? req0_done : req1_done) && cyc < 60);
        chk("latency", cyc, exp_lat);
        chk("resp_psel", PSELx, 0);
        chk("resp_penable", PENABLE, 0);
        chk("resp_busy", busy, 1);
        set_valid(id, 1'b0);
        @(posedge PCLK); #1;
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int cyc;
        int who;
        PRESETn = 1'b0;
        drive_req(0, 1'b0, 1'b0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0);
        cfg_waits = 0; cfg_rdata = '0; cfg_err = 1'b0;

        // Reset state
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_psel", PSELx, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_busy", busy, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_done0", req0_done, 0);
        chk("rst_done1", req1_done, 0);
        chk("rst_err0", req0_err, 0);
        chk("rst_err1", req1_err, 0);
        chk("rst_rdata0", req0_rdata, 0);
        chk("rst_rdata1", req1_rdata, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Single write, zero wait
        do_txn(0, 1'b1, 16'h0004, 32'h0000_00A5, 0, 32'h0, 1'b0);
        // Read with three wait states
        do_txn(1, 1'b0, 16'h0008, 32'h0, 3, 32'h0000_005A, 1'b0);
        // Slave error on a read
        do_txn(0, 1'b0, 16'h000C, 32'h0, 0, 32'h0000_0033, 1'b1);
        // Timeout, then a normal transfer
        do_txn(0, 1'b0, 16'h0014, 32'h0, 100, 32'h0000_00EE, 1'b0);
        do_txn(1, 1'b1, 16'h0018, 32'h0000_1234, 1, 32'h0, 1'b0);

        // Reset in the middle of a req0 ACCESS with a hung slave
        q.push_back(mk(0, 1'b0, 16'h0040, 32'h0, 32'h0, 1'b0));
        cfg_waits = 100;
        drive_req(0, 1'b1, 1'b0, 16'h0040, 32'h0);
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        chk("rst_mid_pre_penable", PENABLE, 1);
        PRESETn = 1'b0;
        drive_req(0, 1'b1, 1'b1, 16'h0010, 32'hC0DE_0001);
        drive_req(1, 1'b1, 1'b0, 16'h0020, 32'h0);
        #1;
        chk("rst_mid_psel", PSELx, 0);
        chk("rst_mid_penable", PENABLE, 0);
        chk("rst_mid_busy", busy, 0);
        q.delete();
        q.push_back(mk(0, 1'b1, 16'h0010, 32'hC0DE_0001, 32'h0, 1'b0));
        q.push_back(mk(1, 1'b0, 16'h0020, 32'h0, 32'h77, 1'b0));
        q.push_back(mk(0, 1'b1, 16'h0010, 32'hC0DE_0001, 32'h0, 1'b0));
        q.push_back(mk(1, 1'b0, 16'h0020, 32'h0, 32'h77, 1'b0));
        cfg_waits = 0; cfg_rdata = 32'h77; cfg_err = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_hold_done0", req0_done, 0);
        chk("rst_hold_done1", req1_done, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Both requesters keep asking: grants must alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin
                @(posedge PCLK); #1;
                cyc++;
            end while (!(req0_done || req1_done) && cyc < 20);
            who = req1_done ? 1 : 0;
            chk("tie_order", who, k % 2);
            chk("tie_latency", cyc, 3);
            set_valid(who, 1'b0);
            @(posedge PCLK); #1;
            if (k < 2) set_valid(who, 1'b1);
        end

        repeat (2) @(posedge PCLK);
        #1;
        chk("final_busy", busy, 0);
        chk("final_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
